// File: rtl/divider_pkg.sv
// Shared definitions for the shift/subtract divider.
//   DIV_WIDTH   : default operand/result width
//   div_state_e : controller state encoding
package divider_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/left_shift_register.sv
// Left-shifting register with parallel load; load has priority over shift.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears contents)
//   enable     : shift left by one, serial_in enters at bit 0
//   load       : parallel load from in
//   in         : parallel load value
//   serial_in  : bit shifted into the LSB
//   out        : current register contents
module left_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = in;
    end else if (enable) begin
      data_d = {data_q[WIDTH-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign out = data_q;

endmodule

// File: rtl/shift_subtract_divider.sv
// Multi-cycle restoring divider, signed (mode=0) or unsigned (mode=1).
// One quotient bit per cycle on operand magnitudes; sign fix-up at the end.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// LOAD  | compute magnitudes, clear accumulator, or short-cut divide-by-zero
// ITER  | one restoring step per cycle, WIDTH cycles
// FIX   | apply result signs and register quotient/remainder
// DONE  | one-cycle done pulse
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start, mode         : request pulse and signedness (0 signed, 1 unsigned)
//   dividend, divisor   : operands, sampled with start
//   quotient, remainder : results, held until the next completion
//   busy, done          : operation in progress / completion pulse
//   div_by_zero         : divisor was zero, held until the next completion
module shift_subtract_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_e state_q, state_d;

  logic             mode_q, mode_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH:0]   dvs_mag_q, dvs_mag_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // {acc, q} working register
  logic               sr_load, sr_enable, sr_serial;
  logic [2*WIDTH-1:0] sr_in, sr_out;

  logic [WIDTH-1:0] acc, qv, acc_diff;
  logic [WIDTH:0]   acc_sh;
  logic             sub_ok;
  logic             dvd_neg, dvs_neg;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  left_shift_register #(
    .WIDTH(2*WIDTH)
  ) u_acc_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (sr_enable),
    .load     (sr_load),
    .in       (sr_in),
    .serial_in(sr_serial),
    .out      (sr_out)
  );

  assign acc      = sr_out[2*WIDTH-1:WIDTH];
  assign qv       = sr_out[WIDTH-1:0];
  // Accumulator after the shift, one bit wider so the trial compare is exact.
  assign acc_sh   = {acc, qv[WIDTH-1]};
  assign sub_ok   = (acc_sh >= dvs_mag_q);
  assign acc_diff = WIDTH'(acc_sh - dvs_mag_q);
  assign dvd_neg  = ~mode_q & dividend_q[WIDTH-1];
  assign dvs_neg  = ~mode_q & divisor_q[WIDTH-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      dvs_mag_q   <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      dvs_mag_q   <= dvs_mag_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = (divisor_q == '0) ? ST_DONE : ST_ITER;
      ST_ITER: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_LOAD, ST_ITER, ST_FIX: busy = 1'b1;
      ST_DONE:                  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_comb begin
    mode_d      = mode_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    dvs_mag_d   = dvs_mag_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    sr_load     = 1'b0;
    sr_enable   = 1'b0;
    sr_serial   = 1'b0;
    sr_in       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = mode;
          dividend_d = dividend;
          divisor_d  = divisor;
        end
      end
      ST_LOAD: begin
        if (divisor_q == '0) begin
          quotient_d  = '1;
          remainder_d = dividend_q;
          dbz_d       = 1'b1;
        end else begin
          sr_load   = 1'b1;
          sr_in     = {{WIDTH{1'b0}}, dvd_neg ? twos_neg(dividend_q) : dividend_q};
          dvs_mag_d = {1'b0, dvs_neg ? twos_neg(divisor_q) : divisor_q};
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          cnt_d     = CW'(WIDTH - 1);
        end
      end
      ST_ITER: begin
        // A failed trial subtract is exactly a plain left shift with a 0 in;
        // only a successful one needs the parallel load.
        if (sub_ok) begin
          sr_load = 1'b1;
          sr_in   = {acc_diff, qv[WIDTH-2:0], 1'b1};
        end else begin
          sr_enable = 1'b1;
        end
        cnt_d = cnt_q - CW'(1);
      end
      ST_FIX: begin
        quotient_d  = neg_quo_q ? twos_neg(qv) : qv;
        remainder_d = neg_rem_q ? twos_neg(acc) : acc;
        dbz_d       = 1'b0;
      end
      default: ;
    endcase
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_subtract_divider.sv
module tb_shift_subtract_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int checks = 0;
  int failures = 0;

  shift_subtract_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division with the result rules of the divider.
  function automatic void model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (m) begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge just after the start edge; leaves at the negedge
  // of the IDLE cycle that follows the done pulse.
  task automatic wait_done(input string tag, input logic m, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         ez;
    int           edges = 0;
    int           busy_cnt = 0;
    int           done_at = -1;
    int           exp_edges;
    model(m, a, b, eq, er, ez);
    exp_edges = ez ? 1 : W + 2;
    for (int k = 0; k < 60; k++) begin
      if (done === 1'b1) begin
        done_at = edges;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, " latency"}, done_at, exp_edges);
    chk({tag, " busy_cycles"}, busy_cnt, ez ? 1 : W + 2);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " quotient_hold"}, quotient, eq);
  endtask

  task automatic run_op(input string tag, input logic m, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    mode     = m;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    mode     = 1'($urandom);
    dividend = W'($urandom);
    divisor  = W'($urandom);
    wait_done(tag, m, a, b);
  endtask

  initial begin
    logic         rm;
    logic [W-1:0] ra, rb;
    logic [W-1:0] bq, br;
    logic         bm;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset quotient", quotient, '0);
    chk("reset remainder", remainder, '0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset div_by_zero", div_by_zero, 1'b0);
    rst_n = 1'b1;

    // Directed cases; the first start right after reset release
    run_op("u100/7", 1'b1, 16'd100, 16'd7);
    run_op("s-7/2", 1'b0, 16'hFFF9, 16'd2);
    run_op("s7/-2", 1'b0, 16'd7, 16'hFFFE);
    run_op("uFFFF/1", 1'b1, 16'hFFFF, 16'd1);
    run_op("s8000/-1", 1'b0, 16'h8000, 16'hFFFF);
    run_op("s1234/0", 1'b0, 16'd1234, 16'd0);
    run_op("u1234/0", 1'b1, 16'd1234, 16'd0);
    run_op("s8000/8000", 1'b0, 16'h8000, 16'h8000);
    run_op("u0/5", 1'b1, 16'd0, 16'd5);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom);
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: rb = W'($urandom_range(0, 1)) ? 16'hFFFF : 16'h8000;
        default: rb = W'($urandom);
      endcase
      run_op("random", rm, ra, rb);
    end

    // Reset in the 5th ITER cycle after a completed op left nonzero results
    run_op("pre_reset", 1'b1, 16'd100, 16'd7);
    mode = 1'b1; dividend = 16'd999; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midreset quotient", quotient, '0);
    chk("midreset remainder", remainder, '0);
    chk("midreset busy", busy, 1'b0);
    chk("midreset done", done, 1'b0);
    chk("midreset div_by_zero", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("u50/5", 1'b1, 16'd50, 16'd5);

    // Start held while busy with new operands: ignored, then accepted in order
    bm = 1'b0; bq = 16'hFF9C; br = 16'd9;
    mode = 1'b1; dividend = 16'd1000; divisor = 16'd33; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mode = bm; dividend = bq; divisor = br;
    wait_done("b2b_first", 1'b1, 16'd1000, 16'd33);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mode = 1'b1; dividend = 16'h1234; divisor = 16'h0;
    wait_done("b2b_second", bm, bq, br);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
